touch_adc_responder: RTL and testbench

- Synthesizable model of the touchscreen ADC (ADS7843-style) at the far end of the touchpad serial link.
- Acts as the responder to the touchpad controller: samples its chip-select, serial clock and command bit stream, decodes the 8-bit control byte, drives BUSY, and shifts back a 12-bit (or 8-bit) conversion result.
- Used in-system to replace the physical ADC for loopback and bring-up, and in benches as a cycle-accurate peer of the controller.

---
 rtl/touch_adc_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_touch_adc_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_adc_responder.sv
// touch_adc_responder
//
// Synthesizable stand-in for an ADS7843-style touchscreen ADC. It sits at the far
// end of the touchpad serial link and answers the touchpad controller. It samples
// the chip select, serial clock and command stream, decodes the 8-bit control byte,
// drives BUSY, and shifts back a RES_W-bit result (or its upper 8 bits in 8-bit
// mode). All logic runs on cclk, so the serial pins are oversampled.
//
// Optional feature: define TOUCH_PENIRQ_EN to add pen_down / penirq_n.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on touch_clk, touch_csb and data_out (2 or 3)
//   RES_W        conversion result width (must be >= 8)
//
// Ports:
//   cclk        system clock; all logic on rising edge
//   rst         asynchronous active-high reset
//   touch_clk   serial clock from the controller (asynchronous to cclk)
//   touch_csb   active-low chip select from the controller
//   data_out    controller's serial command output (this block's DIN)
//   data_in     serial result to the controller (this block's DOUT)
//   touch_busy  conversion busy flag
//   x_val       result returned for X channel requests
//   y_val       result returned for Y channel requests
//   z_val       result returned for Z1 channel requests
//   pen_down    (TOUCH_PENIRQ_EN only) pen contact input
//   penirq_n    (TOUCH_PENIRQ_EN only) active-low pen interrupt, registered
//   cmd_byte    last complete control byte received
//   cmd_valid   one-cclk pulse when cmd_byte updates
module touch_adc_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RES_W       = 12
) (
  input  logic             cclk,
  input  logic             rst,
  input  logic             touch_clk,
  input  logic             touch_csb,
  input  logic             data_out,
  output logic             data_in,
  output logic             touch_busy,
  input  logic [RES_W-1:0] x_val,
  input  logic [RES_W-1:0] y_val,
  input  logic [RES_W-1:0] z_val,
`ifdef TOUCH_PENIRQ_EN
  input  logic             pen_down,
  output logic             penirq_n,
`endif
  output logic [7:0]       cmd_byte,
  output logic             cmd_valid
);

  localparam int unsigned CntW = $clog2(RES_W + 1);

  localparam logic [CntW-1:0] CntLastCmd = CntW'(7);
  localparam logic [CntW-1:0] CntFull    = CntW'(RES_W);
  localparam logic [CntW-1:0] CntByte    = CntW'(8);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StCmd,
    StBusyWait,
    StBusy,
    StShift
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and serial clock edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] csb_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   clk_prev_q;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '0;
      // Deselected out of reset so no spurious transaction starts.
      csb_sync_q <= '1;
      din_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], touch_clk};
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], touch_csb};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], data_out};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  logic clk_s;
  logic csb_s;
  logic din_s;
  logic clk_rise;
  logic clk_fall;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;

  // ---------------------------------------------------------------------------
  // Transaction state
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  // Holds the seven most recent command bits; the eighth arrives with the final rise.
  logic [6:0]        cmd_sh_q,    cmd_sh_d;
  logic [CntW-1:0]   bitcnt_q,    bitcnt_d;
  logic [RES_W-1:0]  shadow_q,    shadow_d;
  logic              mode8_q,     mode8_d;
  logic              data_in_q,   data_in_d;
  logic              busy_q,      busy_d;
  logic [7:0]        cmd_byte_q,  cmd_byte_d;
  logic              cmd_valid_q, cmd_valid_d;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_sh_q    <= '0;
      bitcnt_q    <= '0;
      shadow_q    <= '0;
      mode8_q     <= 1'b0;
      data_in_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_sh_q    <= cmd_sh_d;
      bitcnt_q    <= bitcnt_d;
      shadow_q    <= shadow_d;
      mode8_q     <= mode8_d;
      data_in_q   <= data_in_d;
      busy_q      <= busy_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  // Command byte as it stands once the current DIN bit is shifted in.
  logic [7:0]       cmd_next;
  logic [RES_W-1:0] sel_val;

  assign cmd_next = {cmd_sh_q, din_s};

  always_comb begin
    sel_val = '0;
    case (cmd_next[6:4])
      3'b101:  sel_val = x_val;
      3'b001:  sel_val = y_val;
      3'b011:  sel_val = z_val;
      default: sel_val = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_sh_d    = cmd_sh_q;
    bitcnt_d    = bitcnt_q;
    shadow_d    = shadow_q;
    mode8_d     = mode8_q;
    data_in_d   = data_in_q;
    busy_d      = busy_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;

    if (csb_s) begin
      // Deselect overrides any clock edge seen in the same cycle and drops partial work.
      state_d   = StIdle;
      cmd_sh_d  = '0;
      bitcnt_d  = '0;
      data_in_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWaitStart;
        end

        StWaitStart: begin
          // Leading zeros are skipped; the first 1 is the start bit (cmd bit 7).
          if (clk_rise && din_s) begin
            cmd_sh_d = 7'h01;
            bitcnt_d = CntOne;
            state_d  = StCmd;
          end
        end

        StCmd: begin
          if (clk_rise) begin
            cmd_sh_d = cmd_next[6:0];
            bitcnt_d = bitcnt_q + CntOne;
            if (bitcnt_q == CntLastCmd) begin
              cmd_valid_d = 1'b1;
              cmd_byte_d  = cmd_next;
              // Shadow the result so later x/y/z changes cannot corrupt the reply.
              shadow_d    = sel_val;
              mode8_d     = cmd_next[3];
              bitcnt_d    = '0;
              state_d     = StBusyWait;
            end
          end
        end

        StBusyWait: begin
          if (clk_fall) begin
            busy_d  = 1'b1;
            state_d = StBusy;
          end
        end

        StBusy: begin
          if (clk_fall) begin
            busy_d    = 1'b0;
            data_in_d = shadow_q[RES_W-1];
            shadow_d  = shadow_q << 1;
            bitcnt_d  = CntOne;
            state_d   = StShift;
          end
        end

        StShift: begin
          // 8-bit mode sends only the first eight bits shifted out, i.e. the upper byte.
          if (clk_fall) begin
            if (bitcnt_q == (mode8_q ? CntByte : CntFull)) begin
              data_in_d = 1'b0;
              bitcnt_d  = '0;
              shadow_d  = '0;
              state_d   = StWaitStart;
            end else begin
              data_in_d = shadow_q[RES_W-1];
              shadow_d  = shadow_q << 1;
              bitcnt_d  = bitcnt_q + CntOne;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign data_in    = data_in_q;
  assign touch_busy = busy_q;
  assign cmd_byte   = cmd_byte_q;
  assign cmd_valid  = cmd_valid_q;

`ifdef TOUCH_PENIRQ_EN
  // Pen interrupt is only reported while idle and the last command selected PD=00.
  logic penirq_n_q;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      penirq_n_q <= 1'b1;
    end else if ((state_q == StIdle || state_q == StWaitStart) && cmd_byte_q[1:0] == 2'b00) begin
      penirq_n_q <= ~pen_down;
    end else begin
      penirq_n_q <= 1'b1;
    end
  end

  assign penirq_n = penirq_n_q;
`endif

endmodule

// File: tb/tb_touch_adc_responder.sv
// Randomized bench for touch_adc_responder. It drives controller-side serial
// transactions. A transaction-level model predicts DOUT, BUSY, cmd_valid and
// cmd_byte at the pins, and those predictions are delayed by the synchronizer
// latency. A per-cycle compare process checks them against the DUT. Directed
// transactions with literal expectations pin the model down.
module tb_touch_adc_responder;

  localparam int unsigned SS = 2;
  localparam int unsigned RW = 12;
  localparam int unsigned L  = SS + 1;

  logic          cclk      = 1'b0;
  logic          rst       = 1'b1;
  logic          touch_clk = 1'b0;
  logic          touch_csb = 1'b1;
  logic          data_out  = 1'b0;
  logic          data_in;
  logic          touch_busy;
  logic [RW-1:0] x_val = '0;
  logic [RW-1:0] y_val = '0;
  logic [RW-1:0] z_val = '0;
  logic [7:0]    cmd_byte;
  logic          cmd_valid;
`ifdef TOUCH_PENIRQ_EN
  logic          pen_down = 1'b0;
  logic          penirq_n;
`endif

  touch_adc_responder #(
    .SYNC_STAGES(SS),
    .RES_W      (RW)
  ) dut (
    .cclk      (cclk),
    .rst       (rst),
    .touch_clk (touch_clk),
    .touch_csb (touch_csb),
    .data_out  (data_out),
    .data_in   (data_in),
    .touch_busy(touch_busy),
    .x_val     (x_val),
    .y_val     (y_val),
    .z_val     (z_val),
`ifdef TOUCH_PENIRQ_EN
    .pen_down  (pen_down),
    .penirq_n  (penirq_n),
`endif
    .cmd_byte  (cmd_byte),
    .cmd_valid (cmd_valid)
  );

  always #5 cclk = ~cclk;

  int checks   = 0;
  int errors   = 0;
  int cv_count = 0;
  bit cmp_en   = 1'b0;

  // Pin-level expectations, set at the instant the bench moves a pin.
  logic       exp_din  = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_cv   = 1'b0;
  logic [7:0] exp_cmd  = 8'h00;

  logic       hd [L+1];
  logic       hb [L+1];
  logic       hv [L+1];
  logic [7:0] hc [L+1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  function automatic logic [11:0] model_res(input logic [7:0] c, input logic [11:0] x,
                                            input logic [11:0] y, input logic [11:0] z);
    logic [11:0] r;
    case (c[6:4])
      3'b101:  r = x;
      3'b001:  r = y;
      3'b011:  r = z;
      default: r = 12'h000;
    endcase
    // Right-aligned word exactly as it should appear on DOUT.
    return c[3] ? {4'h0, r[11:4]} : r;
  endfunction

  // Outputs observed at a negedge must equal the expectation from L negedges earlier.
  initial begin
    forever begin
      @(negedge cclk);
      if (rst) begin
        for (int i = 0; i <= L; i++) begin
          hd[i] = exp_din;
          hb[i] = exp_busy;
          hv[i] = exp_cv;
          hc[i] = exp_cmd;
        end
      end else begin
        for (int i = L; i > 0; i--) begin
          hd[i] = hd[i-1];
          hb[i] = hb[i-1];
          hv[i] = hv[i-1];
          hc[i] = hc[i-1];
        end
        hd[0] = exp_din;
        hb[0] = exp_busy;
        hv[0] = exp_cv;
        hc[0] = exp_cmd;
        if (cmp_en) begin
          chk("data_in", {31'd0, data_in}, {31'd0, hd[L]});
          chk("touch_busy", {31'd0, touch_busy}, {31'd0, hb[L]});
          chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, hv[L]});
          chk("cmd_byte", {24'd0, cmd_byte}, {24'd0, hc[L]});
        end
        if (cmd_valid) cv_count = cv_count + 1;
      end
    end
  end

  // One controller transaction: lead zeros, 8 command bits, then n+1 more clocks.
  // stop_kind 1 raises csb before pulse stop_at; stop_kind 2 asserts rst there instead.
  // chg 1 randomizes x/y/z during the reply, chg 2 forces them to FFF.
  task automatic txn(input int lead, input logic [7:0] c, input int h, input int stop_at,
                     input int stop_kind, input int chg, input bit raise_csb,
                     output logic [11:0] cap);
    logic [11:0] bits;
    int n;
    int total;
    int k;
    bits  = model_res(c, x_val, y_val, z_val);
    n     = c[3] ? 8 : 12;
    total = lead + 9 + n;
    cap   = 12'h000;
    if (touch_csb) begin
      touch_csb = 1'b0;
      tick(h);
    end
    for (int j = 0; j < total; j++) begin
      if (j == stop_at) begin
        if (stop_kind == 1) begin
          touch_csb = 1'b1;
          exp_din   = 1'b0;
          exp_busy  = 1'b0;
          tick(L + h);
        end else begin
          rst       = 1'b1;
          touch_csb = 1'b1;
          exp_din   = 1'b0;
          exp_busy  = 1'b0;
          exp_cv    = 1'b0;
          exp_cmd   = 8'h00;
          #1;
          chk("rst_data_in", {31'd0, data_in}, 32'd0);
          chk("rst_busy", {31'd0, touch_busy}, 32'd0);
          chk("rst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
          tick(3);
          rst = 1'b0;
          tick(h);
        end
        return;
      end
      if (j < lead) data_out = 1'b0;
      else if (j < lead + 8) data_out = c[7-(j-lead)];
      else data_out = 1'($urandom_range(0, 1));
      if (j == lead + 8) begin
        if (chg == 1) begin
          x_val = 12'($urandom);
          y_val = 12'($urandom);
          z_val = 12'($urandom);
        end else if (chg == 2) begin
          x_val = 12'hFFF;
          y_val = 12'hFFF;
          z_val = 12'hFFF;
        end
      end
      tick(h);
      if (j >= lead + 9 && j < lead + 9 + n) cap = {cap[10:0], data_in};
      touch_clk = 1'b1;
      if (j == lead + 7) begin
        exp_cv  = 1'b1;
        exp_cmd = c;
        tick(1);
        exp_cv  = 1'b0;
        tick(h - 1);
      end else begin
        tick(h);
      end
      touch_clk = 1'b0;
      k = j - lead - 6;
      if (k == 1) begin
        exp_busy = 1'b1;
      end else if (k >= 2 && k <= n + 1) begin
        exp_busy = 1'b0;
        exp_din  = bits[n-k+1];
      end else if (k == n + 2) begin
        exp_din = 1'b0;
      end
    end
    tick(h);
    if (raise_csb) begin
      touch_csb = 1'b1;
      tick(L + h);
    end
  endtask

  initial begin
    logic [11:0] cap;
    logic [11:0] want;
    logic [7:0]  c;
    int          cv0;
    int          lead;
    int          h;
    int          n;
    int          stop_at;

    tick(4);
    chk("reset_data_in", {31'd0, data_in}, 32'd0);
    chk("reset_busy", {31'd0, touch_busy}, 32'd0);
    chk("reset_cmd_byte", {24'd0, cmd_byte}, 32'd0);
    chk("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    rst = 1'b0;
    tick(4);
    cmp_en = 1'b1;

    // X read, 12-bit.
    x_val = 12'hA5C;
    cv0 = cv_count;
    txn(0, 8'hD0, 6, -1, 0, 0, 1'b1, cap);
    chk("x_read_bits", {20'd0, cap}, 32'h0000_0A5C);
    chk("x_read_cmd_byte", {24'd0, cmd_byte}, 32'h0000_00D0);
    chk("x_read_cv_count", cv_count - cv0, 32'd1);

    // Y read, 8-bit mode.
    y_val = 12'h3F7;
    txn(0, 8'h98, 5, -1, 0, 0, 1'b1, cap);
    chk("y8_bits", {20'd0, cap}, 32'h0000_003F);
    chk("y8_cmd_byte", {24'd0, cmd_byte}, 32'h0000_0098);

    // Leading zeros, Z read, inputs forced to FFF during the reply.
    z_val = 12'h123;
    txn(3, 8'hB0, 5, -1, 0, 2, 1'b1, cap);
    chk("z_shadow_bits", {20'd0, cap}, 32'h0000_0123);
    chk("z_cmd_byte", {24'd0, cmd_byte}, 32'h0000_00B0);

    // Abort after five command bits, then a clean X read.
    cv0 = cv_count;
    txn(0, 8'hD0, 6, 5, 1, 0, 1'b1, cap);
    chk("abort_cv_count", cv_count - cv0, 32'd0);
    chk("abort_cmd_byte", {24'd0, cmd_byte}, 32'h0000_00B0);
    chk("abort_data_in", {31'd0, data_in}, 32'd0);
    x_val = 12'hA5C;
    txn(0, 8'hD0, 6, -1, 0, 0, 1'b1, cap);
    chk("post_abort_bits", {20'd0, cap}, 32'h0000_0A5C);

    // Reset in the middle of the reply, then resume.
    txn(0, 8'hD0, 6, 13, 2, 0, 1'b1, cap);
    chk("post_rst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
    txn(1, 8'hD0, 4, -1, 0, 0, 1'b1, cap);
    chk("post_rst_bits", {20'd0, cap}, 32'h0000_0A5C);

    // Randomized transactions, with back-to-back and aborted variants.
    repeat (40) begin
      x_val = 12'($urandom);
      y_val = 12'($urandom);
      z_val = 12'($urandom);
      lead  = int'($urandom_range(0, 3));
      c     = {1'b1, 7'($urandom)};
      h     = int'($urandom_range(4, 7));
      n     = c[3] ? 8 : 12;
      want  = model_res(c, x_val, y_val, z_val);
      stop_at = -1;
      if ($urandom_range(0, 4) == 0) stop_at = int'($urandom_range(0, lead + 8 + n));
      txn(lead, c, h, stop_at, 1, 1, 1'($urandom_range(0, 1)), cap);
      if (stop_at < 0) chk("rand_bits", {20'd0, cap}, {20'd0, want});
    end

    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
